// File: rtl/tri_lcb_seq_if.sv
// Control/status bundle between a latch-group sequencer and its owner.
// The master side drives requests; the slave side (the sequencer) drives latch controls.
interface tri_lcb_seq_if #(
  parameter int GROUPS = 4
);
  logic              start;
  logic              stop_req;
  logic [GROUPS-1:0] grp_en;
  logic [GROUPS-1:0] act_req;
  logic [GROUPS-1:0] act;
  logic [GROUPS-1:0] thold_b;
  logic [GROUPS-1:0] sreset;
  logic [GROUPS-1:0] released;
  logic              busy;
  logic              running;
  logic              done;

  modport master (
    output start, stop_req, grp_en, act_req,
    input  act, thold_b, sreset, released, busy, running, done
  );

  modport slave (
    input  start, stop_req, grp_en, act_req,
    output act, thold_b, sreset, released, busy, running, done
  );
endinterface

// File: rtl/tri_lcb_seq.sv
// Start/stop sequencer for banks of tri_nlat latches: timed sreset, then staggered
// ascending release from thold, and staggered descending re-hold on stop.
module tri_lcb_seq #(
  parameter int GROUPS       = 4,
  parameter int RESET_CYCLES = 4,
  parameter int STAGGER      = 2,
  parameter int CNT_WIDTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  tri_lcb_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SRESET  = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_RST_LD = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_STG_LD = CNT_WIDTH'(STAGGER - 1);

  state_t                r_state, w_state_nxt;
  logic [GROUPS-1:0]     r_mask,  w_mask_nxt;
  logic [GROUPS-1:0]     r_rel,   w_rel_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt,   w_cnt_nxt;
  logic                  r_done,  w_done_nxt;

  logic [CNT_WIDTH-1:0]  w_cnt_dec;
  logic [GROUPS-1:0]     w_pend;
  logic [GROUPS-1:0]     w_lo;
  logic [GROUPS-1:0]     w_hi;
  logic                  w_in_sres;

  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CNT_WIDTH'(1);

  // Next group to release is the lowest enabled one still held.
  assign w_pend = r_mask & ~r_rel;
  assign w_lo   = w_pend & (~w_pend + GROUPS'(1));

  always_comb begin
    w_hi = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (r_rel[g]) begin
        w_hi    = '0;
        w_hi[g] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_rel   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_rel   <= w_rel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_rel_nxt   = r_rel;
    w_cnt_nxt   = w_cnt_dec;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.grp_en != '0)) begin
          w_state_nxt = S_SRESET;
          w_mask_nxt  = bus.grp_en;
          w_cnt_nxt   = LP_RST_LD;
        end
      end
      S_SRESET: begin
        if (bus.stop_req) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == '0) begin
          // First release lands on the SRESET exit edge so thold_b never dips.
          w_state_nxt = S_RELEASE;
          w_rel_nxt   = r_rel | w_lo;
          w_cnt_nxt   = LP_STG_LD;
        end
      end
      S_RELEASE: begin
        if (bus.stop_req) begin
          w_state_nxt = S_DRAIN;
          w_rel_nxt   = r_rel & ~w_hi;
          w_cnt_nxt   = LP_STG_LD;
        end else if (w_pend == '0) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = LP_STG_LD;
        end else if (r_cnt == '0) begin
          w_rel_nxt   = r_rel | w_lo;
          w_cnt_nxt   = LP_STG_LD;
        end
      end
      S_RUN: begin
        if (bus.stop_req) begin
          w_state_nxt = S_DRAIN;
          w_rel_nxt   = r_rel & ~w_hi;
          w_cnt_nxt   = LP_STG_LD;
        end
      end
      S_DRAIN: begin
        if (r_rel == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_rel_nxt   = r_rel & ~w_hi;
          w_cnt_nxt   = LP_STG_LD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rel_nxt   = '0;
      end
    endcase
  end

  // act follows act_req combinationally so functional gating has no extra latency.
  assign w_in_sres    = (r_state == S_SRESET);
  assign bus.sreset   = {GROUPS{w_in_sres}} & r_mask;
  assign bus.thold_b  = r_rel | ({GROUPS{w_in_sres}} & r_mask);
  assign bus.act      = r_rel & bus.act_req;
  assign bus.released = r_rel;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.running  = (r_state == S_RUN);
  assign bus.done     = r_done;

endmodule
